// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low digit/dash patterns, FSM states
// and the decoder result classification.
package seg_pkg;

   localparam logic [7:0] SEG_0    = 8'hC0;
   localparam logic [7:0] SEG_1    = 8'hF9;
   localparam logic [7:0] SEG_2    = 8'hA4;
   localparam logic [7:0] SEG_3    = 8'hB0;
   localparam logic [7:0] SEG_4    = 8'h99;
   localparam logic [7:0] SEG_5    = 8'h92;
   localparam logic [7:0] SEG_6    = 8'h82;
   localparam logic [7:0] SEG_7    = 8'hF8;
   localparam logic [7:0] SEG_8    = 8'h80;
   localparam logic [7:0] SEG_9    = 8'h98;
   localparam logic [7:0] SEG_DASH = 8'hBF;

   localparam logic [6:0] VALUE_OVF = 7'd127;

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      ACC,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      RES_OK,
      RES_OVF,
      RES_ERR
   } result_e;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational decode of one active-low segment pattern into a BCD digit.
// Only exact 8-bit matches are legal; a lit decimal point makes the code illegal.
module seg_digit_decode
   import seg_pkg::*;
(
   input  logic [7:0] pattern,
   output logic [3:0] digit,
   output logic       is_dash,
   output logic       illegal
);

   // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      digit   = 4'd0;
      is_dash = 1'b0;
      illegal = 1'b0;
      case (pattern)
         SEG_0:    digit = 4'd0;
         SEG_1:    digit = 4'd1;
         SEG_2:    digit = 4'd2;
         SEG_3:    digit = 4'd3;
         SEG_4:    digit = 4'd4;
         SEG_5:    digit = 4'd5;
         SEG_6:    digit = 4'd6;
         SEG_7:    digit = 4'd7;
         SEG_8:    digit = 4'd8;
         SEG_9:    digit = 4'd9;
         SEG_DASH: is_dash = 1'b1;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg2bin_decoder.sv
// Converts a captured two-digit seven-segment display reading into binary by
// repeated addition of ten, flagging overflow (-- --) and illegal/mixed patterns.
module seg2bin_decoder
   import seg_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] seg0,
   input  logic [7:0] seg1,
   output logic       busy,
   output logic       done,
   output logic [6:0] value,
   output logic       gt99,
   output logic       err
);

   state_e     state_q, state_d;
   result_e    kind_q,  kind_d;
   logic [7:0] seg0_q,  seg0_d;
   logic [7:0] seg1_q,  seg1_d;
   logic [6:0] acc_q,   acc_d;
   logic [3:0] cnt_q,   cnt_d;
   logic       done_q,  done_d;
   logic [6:0] value_q, value_d;
   logic       gt99_q,  gt99_d;
   logic       err_q,   err_d;

   logic [3:0] ones_digit, tens_digit;
   logic       ones_dash,  tens_dash;
   logic       ones_ill,   tens_ill;

   seg_digit_decode u_ones (
      .pattern (seg0_q),
      .digit   (ones_digit),
      .is_dash (ones_dash),
      .illegal (ones_ill)
   );

   seg_digit_decode u_tens (
      .pattern (seg1_q),
      .digit   (tens_digit),
      .is_dash (tens_dash),
      .illegal (tens_ill)
   );

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      seg0_d  = seg0_q;
      seg1_d  = seg1_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      value_d = value_q;
      gt99_d  = gt99_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               seg0_d  = seg0;
               seg1_d  = seg1;
               state_d = DECODE;
            end
         end

         DECODE: begin
            if (ones_ill || tens_ill || (ones_dash ^ tens_dash)) begin
               acc_d   = 7'd0;
               cnt_d   = 4'd0;
               kind_d  = RES_ERR;
               state_d = DONE;
            end else if (ones_dash && tens_dash) begin
               acc_d   = VALUE_OVF;
               cnt_d   = 4'd0;
               kind_d  = RES_OVF;
               state_d = DONE;
            end else begin
               acc_d   = {3'b000, ones_digit};
               cnt_d   = tens_digit;
               kind_d  = RES_OK;
               state_d = ACC;
            end
         end

         // One ten per cycle; max 9 + 9*10 = 99 fits 7 bits.
         ACC: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end else begin
               acc_d = acc_q + 7'd10;
               cnt_d = cnt_q - 4'd1;
            end
         end

         // Results are registered here so they stay stable until the next done.
         DONE: begin
            done_d  = 1'b1;
            value_d = acc_q;
            gt99_d  = (kind_q == RES_OVF);
            err_d   = (kind_q == RES_ERR);
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         kind_q  <= RES_OK;
         seg0_q  <= 8'h00;
         seg1_q  <= 8'h00;
         acc_q   <= 7'd0;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
         value_q <= 7'd0;
         gt99_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         seg0_q  <= seg0_d;
         seg1_q  <= seg1_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         value_q <= value_d;
         gt99_q  <= gt99_d;
         err_q   <= err_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign value = value_q;
   assign gt99  = gt99_q;
   assign err   = err_q;

endmodule

// File: tb/tb_seg2bin_decoder.sv
// Directed self-checking bench for seg2bin_decoder: latency, results, error
// classes, mid-conversion reset and held-start behaviour.
module tb_seg2bin_decoder;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] seg0;
   logic [7:0] seg1;
   logic       busy;
   logic       done;
   logic [6:0] value;
   logic       gt99;
   logic       err;

   int compared   = 0;
   int mismatched = 0;

   seg2bin_decoder dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .seg0  (seg0),
      .seg1  (seg1),
      .busy  (busy),
      .done  (done),
      .value (value),
      .gt99  (gt99),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge, scramble inputs after capture, wait for done.
   task automatic run_conv(input logic [7:0] s1, input logic [7:0] s0,
                           output int lat, output int busy_cyc);
      seg1  = s1;
      seg0  = s0;
      start = 1'b1;
      tick();
      start    = 1'b0;
      seg0     = 8'hFF;
      seg1     = 8'hFF;
      lat      = 0;
      busy_cyc = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cyc++;
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat, bcyc, ndone, first_done, second_done, v37;

      reset = 1'b1;
      start = 1'b0;
      seg0  = 8'hFF;
      seg1  = 8'hFF;
      tick();
      tick();
      reset = 1'b0;
      check("rst_busy",  busy,  0);
      check("rst_done",  done,  0);
      check("rst_value", value, 0);
      check("rst_gt99",  gt99,  0);
      check("rst_err",   err,   0);

      run_conv(8'hC0, 8'hC0, lat, bcyc);
      check("c00_latency", lat,   3);
      check("c00_value",   value, 0);
      check("c00_err",     err,   0);
      check("c00_gt99",    gt99,  0);

      // Issued straight from the done cycle: back-to-back conversion.
      run_conv(8'h98, 8'h98, lat, bcyc);
      check("c99_latency", lat,   12);
      check("c99_value",   value, 99);
      check("c99_busy",    bcyc,  12);
      tick();
      check("c99_done_one_cycle", done,  0);
      check("c99_value_held",     value, 99);

      run_conv(8'hBF, 8'hBF, lat, bcyc);
      check("ovf_latency", lat,   2);
      check("ovf_value",   value, 127);
      check("ovf_gt99",    gt99,  1);
      check("ovf_err",     err,   0);

      run_conv(8'hA4, 8'hBF, lat, bcyc);
      check("mix_latency", lat,   2);
      check("mix_err",     err,   1);
      check("mix_value",   value, 0);
      check("mix_gt99",    gt99,  0);

      run_conv(8'hC0, 8'h40, lat, bcyc);
      check("dp_latency", lat,   2);
      check("dp_err",     err,   1);
      check("dp_value",   value, 0);

      // Reset on the third edge after start aborts the 54 conversion.
      seg1  = 8'h92;
      seg0  = 8'h99;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy",  busy,  0);
      check("abort_done",  done,  0);
      check("abort_value", value, 0);
      check("abort_gt99",  gt99,  0);
      check("abort_err",   err,   0);
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         if (done) ndone++;
         tick();
      end
      check("abort_no_done", ndone, 0);
      run_conv(8'h92, 8'h99, lat, bcyc);
      check("c54_latency", lat,   8);
      check("c54_value",   value, 54);

      // Start held high through a conversion of 37 and one edge past its done.
      seg1        = 8'hB0;
      seg0        = 8'hF8;
      start       = 1'b1;
      ndone       = 0;
      first_done  = -1;
      second_done = -1;
      v37         = -1;
      tick();
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 7) start = 1'b0;
         if (done) begin
            ndone++;
            if (first_done < 0) first_done = c;
            else if (second_done < 0) second_done = c;
         end
         if (c == 6) v37 = value;
      end
      check("held_done_count",  ndone,       2);
      check("held_first_done",  first_done,  6);
      check("held_second_done", second_done, 13);
      check("held_value",       v37,         37);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
